cache_arbiter: RTL and testbench

Registered arbiter that shares the single physical-memory port between the I-cache and the D-cache line-fill/write-back interfaces. Latches the winning request's command, address and write data, holds the memory command until pmem_resp, captures the read line, then returns a one-cycle response to the winner. D-cache has priority by default. A starvation counter forces an I-cache grant after STARVE_LIMIT consecutive D grants taken while I was waiting.

---
 rtl/cache_arbiter_pkg.sv | 19 +
 rtl/cache_arbiter_starve_ctr.sv | 46 ++++
 rtl/cache_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cache_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory types plus the state encoding and defaults used by
// the I/D cache arbiter (cache_arbiter) and its starvation counter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_line;

    // Consecutive D grants (with I waiting) tolerated before I is forced to win.
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_starve_ctr.sv
// arb_starve_ctr: counts D grants taken while the I-cache is waiting and
// raises force_i_o once STARVE_LIMIT of them have happened back to back.
module arb_starve_ctr
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_d_i,
    input  logic grant_i_i,
    input  logic i_pending_i,
    output logic force_i_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: any I grant or an uncontested D grant clears, a contested D grant saturates upward.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_i_i) begin
            cnt_d = 4'd0;
        end else if (grant_d_i) begin
            if (!i_pending_i) begin
                cnt_d = 4'd0;
            end else if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_i_o = (cnt_q == LIMIT);

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the I-cache and the
// D-cache. D has priority unless the starvation counter forces an I grant.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int ADDR_W       = $bits(lc3b_word),
    parameter int LINE_W       = $bits(lc3b_c_line)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       i_grant_cnt,
    output logic [15:0]       d_grant_cnt,
    output logic [15:0]       conflict_cnt
`endif
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic              grant_i;
    logic              grant_d;
    logic              force_i;
    logic              d_req;
    logic              in_grant;
    logic              d_is_write;

    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              op_read_q;
    logic              op_write_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;

    assign d_req      = d_mem_read | d_mem_write;
    assign d_is_write = d_mem_write & ~d_mem_read;

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .grant_d_i   (grant_d),
        .grant_i_i   (grant_i),
        .i_pending_i (i_mem_read),
        .force_i_o   (force_i)
    );

    // Next-state and grant decisions; grants only ever fire from IDLE.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && !(i_mem_read && force_i)) begin
                    state_d = GRANT_D;
                    grant_d = 1'b1;
                end else if (i_mem_read) begin
                    state_d = GRANT_I;
                    grant_i = 1'b1;
                end
            end
            GRANT_I: if (pmem_resp) state_d = RESP_I;
            GRANT_D: if (pmem_resp) state_d = RESP_D;
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winner's command at grant time and capture read lines on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            op_read_q  <= 1'b0;
            op_write_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant_d) begin
                addr_q     <= d_mem_address;
                op_read_q  <= d_mem_read;
                op_write_q <= d_is_write;
                if (d_is_write) begin
                    wdata_q <= d_mem_wdata;
                end
            end else if (grant_i) begin
                addr_q     <= i_mem_address;
                op_read_q  <= 1'b1;
                op_write_q <= 1'b0;
            end
            if (pmem_resp && op_read_q) begin
                if (state_q == GRANT_I) begin
                    i_rdata_q <= pmem_rdata;
                end
                if (state_q == GRANT_D) begin
                    d_rdata_q <= pmem_rdata;
                end
            end
        end
    end

    assign in_grant     = (state_q == GRANT_I) || (state_q == GRANT_D);
    assign pmem_read    = in_grant & op_read_q;
    assign pmem_write   = in_grant & op_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_mem_resp   = (state_q == RESP_I);
    assign d_mem_resp   = (state_q == RESP_D);
    assign i_mem_rdata  = i_rdata_q;
    assign d_mem_rdata  = d_rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] i_grant_cnt_q;
    logic [15:0] d_grant_cnt_q;
    logic [15:0] conflict_cnt_q;

    // Saturating grant and conflict counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_grant_cnt_q  <= 16'd0;
            d_grant_cnt_q  <= 16'd0;
            conflict_cnt_q <= 16'd0;
        end else begin
            if (grant_i && i_grant_cnt_q != 16'hFFFF) begin
                i_grant_cnt_q <= i_grant_cnt_q + 16'd1;
            end
            if (grant_d && d_grant_cnt_q != 16'hFFFF) begin
                d_grant_cnt_q <= d_grant_cnt_q + 16'd1;
            end
            if (state_q == IDLE && i_mem_read && d_req && conflict_cnt_q != 16'hFFFF) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    assign i_grant_cnt  = i_grant_cnt_q;
    assign d_grant_cnt  = d_grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

`ifndef SYNTHESIS
    // A simultaneous D read and write is a protocol violation (read takes precedence).
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(d_mem_read && d_mem_write));
        end
    end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: a behavioural memory plus a
// transaction-level model of who should win each IDLE cycle.
module tb_cache_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_address;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_resp;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_address;
    logic [LINE_W-1:0] d_mem_wdata;
    logic [LINE_W-1:0] d_mem_rdata;
    logic              d_mem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
`ifdef ARB_PERF_CNT_EN
    logic [15:0]       i_grant_cnt;
    logic [15:0]       d_grant_cnt;
    logic [15:0]       conflict_cnt;
`endif

    cache_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .ADDR_W       (ADDR_W),
        .LINE_W       (LINE_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_mem_read    (i_mem_read),
        .i_mem_address (i_mem_address),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_resp    (i_mem_resp),
        .d_mem_read    (d_mem_read),
        .d_mem_write   (d_mem_write),
        .d_mem_address (d_mem_address),
        .d_mem_wdata   (d_mem_wdata),
        .d_mem_rdata   (d_mem_rdata),
        .d_mem_resp    (d_mem_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
`ifdef ARB_PERF_CNT_EN
        ,
        .i_grant_cnt   (i_grant_cnt),
        .d_grant_cnt   (d_grant_cnt),
        .conflict_cnt  (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory contents and the log of every command the memory completed.
    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        int                waitCycles;
    } memTxn_t;

    logic [LINE_W-1:0] memStore [logic [ADDR_W-1:0]];
    memTxn_t           memLog[$];
    memTxn_t           cur;
    bit                memEnable  = 1'b1;
    bit                memBusy    = 1'b0;
    int                memLeft    = 0;
    int                memMinWait = 0;
    int                memMaxWait = 3;

    // Requester model state and expected observable results.
    bit                iPend = 1'b0;
    logic [ADDR_W-1:0] iAddr = '0;
    bit                dPend = 1'b0;
    bit                dIsWrite = 1'b0;
    logic [ADDR_W-1:0] dAddr = '0;
    logic [LINE_W-1:0] dWdata = '0;
    logic [LINE_W-1:0] iRdataExp = '0;
    logic [LINE_W-1:0] dRdataExp = '0;
    int                dStreak = 0;
    int                iGrants = 0;
    int                dGrants = 0;
    int                conflicts = 0;

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [LINE_W-1:0] memLine(input logic [ADDR_W-1:0] a);
        if (memStore.exists(a)) return memStore[a];
        return {8{a ^ 16'h5A5A}};
    endfunction

    function automatic logic [ADDR_W-1:0] randAddr();
        return 16'h0100 + 16'($urandom_range(0, 7) * 16);
    endfunction

    function automatic logic [LINE_W-1:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive the request lines from the requester model.
    task automatic applyStimulus();
        i_mem_read    = iPend;
        i_mem_address = iAddr;
        d_mem_read    = dPend && !dIsWrite;
        d_mem_write   = dPend && dIsWrite;
        d_mem_address = dAddr;
        d_mem_wdata   = dWdata;
    endtask

    // Behavioural physical memory with random wait states.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (memEnable && (pmem_read || pmem_write)) begin
                if (!memBusy) begin
                    memBusy        = 1'b1;
                    cur.rd         = pmem_read;
                    cur.wr         = pmem_write;
                    cur.addr       = pmem_address;
                    cur.wdata      = pmem_wdata;
                    cur.waitCycles = $urandom_range(memMaxWait, memMinWait);
                    memLeft        = cur.waitCycles;
                end else begin
                    checkOutput("pmem_addr_stable", LINE_W'(pmem_address), LINE_W'(cur.addr));
                    checkOutput("pmem_wdata_stable", pmem_wdata, cur.wdata);
                    checkOutput("pmem_cmd_stable", LINE_W'({pmem_read, pmem_write}),
                                LINE_W'({cur.rd, cur.wr}));
                end
                if (memLeft == 0) begin
                    pmem_resp = 1'b1;
                    if (cur.wr) begin
                        memStore[cur.addr] = cur.wdata;
                        pmem_rdata = randLine();
                    end else begin
                        pmem_rdata = memLine(cur.addr);
                    end
                    memLog.push_back(cur);
                    memBusy = 1'b0;
                end else begin
                    memLeft--;
                end
            end else begin
                memBusy = 1'b0;
            end
        end
    end

    // Runs from the start of an IDLE cycle: predicts the winner, follows it to its response.
    task automatic serveOne(input bit withdraw);
        bit      expectD;
        bit      seen;
        int      cyc;
        memTxn_t t;
        applyStimulus();
        checkOutput("idle_i_resp", LINE_W'(i_mem_resp), LINE_W'(0));
        checkOutput("idle_d_resp", LINE_W'(d_mem_resp), LINE_W'(0));
        checkOutput("idle_pmem_cmd", LINE_W'({pmem_read, pmem_write}), LINE_W'(0));
        checkOutput("idle_i_rdata", i_mem_rdata, iRdataExp);
        checkOutput("idle_d_rdata", d_mem_rdata, dRdataExp);
        if (!iPend && !dPend) begin
            @(posedge clk);
            #1;
            return;
        end
        if (iPend && dPend) conflicts++;
        expectD = dPend && !(iPend && dStreak >= LIMIT);
        if (expectD) begin
            dStreak = iPend ? dStreak + 1 : 0;
            dGrants++;
        end else begin
            dStreak = 0;
            iGrants++;
        end
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1 && withdraw) begin
                if (expectD) begin
                    d_mem_read    = 1'b0;
                    d_mem_write   = 1'b0;
                    d_mem_address = ~dAddr;
                end else begin
                    i_mem_read    = 1'b0;
                    i_mem_address = ~iAddr;
                end
            end
            if (expectD) begin
                checkOutput("loser_i_resp", LINE_W'(i_mem_resp), LINE_W'(0));
                seen = d_mem_resp;
            end else begin
                checkOutput("loser_d_resp", LINE_W'(d_mem_resp), LINE_W'(0));
                seen = i_mem_resp;
            end
        end
        checkOutput(expectD ? "d_resp_seen" : "i_resp_seen", LINE_W'(seen), LINE_W'(1));
        if (seen) begin
            checkOutput("resp_pmem_cmd", LINE_W'({pmem_read, pmem_write}), LINE_W'(0));
            checkOutput("memlog_count", LINE_W'(memLog.size()), LINE_W'(1));
            if (memLog.size() > 0) begin
                t = memLog.pop_front();
                checkOutput("latency", LINE_W'(cyc), LINE_W'(t.waitCycles + 2));
                if (expectD) begin
                    checkOutput("d_pmem_addr", LINE_W'(t.addr), LINE_W'(dAddr));
                    checkOutput("d_pmem_op", LINE_W'({t.rd, t.wr}), LINE_W'({!dIsWrite, dIsWrite}));
                    if (dIsWrite) checkOutput("d_pmem_wdata", t.wdata, dWdata);
                    else dRdataExp = memLine(dAddr);
                end else begin
                    checkOutput("i_pmem_addr", LINE_W'(t.addr), LINE_W'(iAddr));
                    checkOutput("i_pmem_op", LINE_W'({t.rd, t.wr}), LINE_W'(2'b10));
                    iRdataExp = memLine(iAddr);
                end
            end
            memLog.delete();
            checkOutput("resp_i_rdata", i_mem_rdata, iRdataExp);
            checkOutput("resp_d_rdata", d_mem_rdata, dRdataExp);
        end
        if (expectD) dPend = 1'b0;
        else iPend = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        iPend = 1'b0;
        dPend = 1'b0;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pmem_read", LINE_W'(pmem_read), LINE_W'(0));
        checkOutput("rst_pmem_write", LINE_W'(pmem_write), LINE_W'(0));
        checkOutput("rst_pmem_addr", LINE_W'(pmem_address), LINE_W'(0));
        checkOutput("rst_pmem_wdata", pmem_wdata, LINE_W'(0));
        checkOutput("rst_resps", LINE_W'({i_mem_resp, d_mem_resp}), LINE_W'(0));
        checkOutput("rst_i_rdata", i_mem_rdata, LINE_W'(0));
        checkOutput("rst_d_rdata", d_mem_rdata, LINE_W'(0));
        reset = 1'b0;

        // I-cache alone, memory answering two cycles after the command.
        memStore[16'h1230] = {16{8'hA5}};
        memMinWait = 2;
        memMaxWait = 2;
        iPend = 1'b1;
        iAddr = 16'h1230;
        serveOne(1'b0);

        // D-cache write-back, then read the same line back.
        dPend = 1'b1; dIsWrite = 1'b1; dAddr = 16'h4000; dWdata = {16{8'h0F}};
        serveOne(1'b0);
        dPend = 1'b1; dIsWrite = 1'b0; dAddr = 16'h4000;
        serveOne(1'b0);

        // Simultaneous requests: D first, then I from the following IDLE.
        memMinWait = 0;
        memMaxWait = 3;
        iPend = 1'b1; iAddr = 16'h0010;
        dPend = 1'b1; dIsWrite = 1'b0; dAddr = 16'h8000;
        serveOne(1'b0);
        serveOne(1'b0);

        // Starvation: D keeps requesting while I waits.
        iPend = 1'b1;
        iAddr = 16'h0770;
        repeat (LIMIT + 1) begin
            if (!dPend) begin
                dPend = 1'b1; dIsWrite = 1'($urandom_range(0, 1));
                dAddr = randAddr(); dWdata = randLine();
            end
            serveOne(1'b0);
        end
        serveOne(1'b0);

        // Randomized traffic, including withdrawn requests during a grant.
        for (int n = 0; n < 60; n++) begin
            if (!iPend && $urandom_range(0, 1) == 1) begin
                iPend = 1'b1; iAddr = randAddr();
            end
            if (!dPend && $urandom_range(0, 1) == 1) begin
                dPend = 1'b1; dIsWrite = 1'($urandom_range(0, 1));
                dAddr = randAddr(); dWdata = randLine();
            end
            serveOne($urandom_range(0, 3) == 0);
        end
        for (int n = 0; n < 4 && (iPend || dPend); n++) serveOne(1'b0);

        // Reset in the middle of a D grant whose memory response never comes.
        memEnable = 1'b0;
        dPend = 1'b1; dIsWrite = 1'b1; dAddr = 16'h2220; dWdata = randLine();
        applyStimulus();
        @(posedge clk);
        #1;
        checkOutput("pre_rst_pmem_write", LINE_W'(pmem_write), LINE_W'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        dPend = 1'b0;
        applyStimulus();
        checkOutput("abort_pmem_cmd", LINE_W'({pmem_read, pmem_write}), LINE_W'(0));
        checkOutput("abort_pmem_addr", LINE_W'(pmem_address), LINE_W'(0));
        checkOutput("abort_pmem_wdata", pmem_wdata, LINE_W'(0));
        checkOutput("abort_resps", LINE_W'({i_mem_resp, d_mem_resp}), LINE_W'(0));
        checkOutput("abort_i_rdata", i_mem_rdata, LINE_W'(0));
        checkOutput("abort_d_rdata", d_mem_rdata, LINE_W'(0));
        iRdataExp = '0; dRdataExp = '0; dStreak = 0;
        iGrants = 0; dGrants = 0; conflicts = 0;
        memEnable = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_no_d_resp", LINE_W'(d_mem_resp), LINE_W'(0));
        iPend = 1'b1; iAddr = 16'h1230;
        serveOne(1'b0);
        iPend = 1'b1; iAddr = 16'h0130;
        dPend = 1'b1; dIsWrite = 1'b0; dAddr = 16'h0140;
        serveOne(1'b0);
        serveOne(1'b0);

`ifdef ARB_PERF_CNT_EN
        checkOutput("perf_i_grants", LINE_W'(i_grant_cnt), LINE_W'(iGrants));
        checkOutput("perf_d_grants", LINE_W'(d_grant_cnt), LINE_W'(dGrants));
        checkOutput("perf_conflicts", LINE_W'(conflict_cnt), LINE_W'(conflicts));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
